op_handler_input_chooser: RTL and testbench
===========================================

Name: op_handler_input_chooser

Overview:
- Routes one op-handler request, the trigger plus the current op, to exactly one of three downstream handlers, chosen by the op command: linear, circular or dummy.
- Returns the selected handler's done to the upstream requester.
- Sits between the op fetch/decode stage (upstream OpHandler_IF master) and the handler bank (three OpHandler_IF slaves).
- Optional output register stage; default is zero-latency combinational routing.

Parameters:
- REGISTER_OUT, 0, 0 = routing is combinational; 1 = all routed outputs registered, one clk latency.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- op  in  op_pkg::op_st  current op (cmd + five args).
- trigger_in  in  1  upstream request (OpHandler_IF slave side).
- done_out  out  1  done returned upstream.
- lin_trigger  out  1  trigger to linear handler (OpHandler_IF master).
- lin_done  in  1  done from linear handler.
- circ_trigger  out  1  trigger to circular handler.
- circ_done  in  1  done from circular handler.
- dummy_trigger  out  1  trigger to dummy handler.
- dummy_done  in  1  done from dummy handler.
- The three handler interfaces and the upstream interface are OpHandler_IF instances in RTL. Flattened names above define the signal set: trigger (master->slave), done (slave->master).

Behaviour:
- Selection decode from op.cmd:
  - OP_CMD_G00, OP_CMD_G01 -> LIN.
  - OP_CMD_G02, OP_CMD_G03 -> CIRC.
  - OP_CMD_G90, OP_CMD_G91 -> DUMMY.
  - Any other or unknown encoding -> DUMMY. Must never hang upstream.
- Trigger routing:
  - Selected handler's trigger = trigger_in.
  - Non-selected triggers = 0.
  - At most one handler trigger high at any time (one-hot-or-zero invariant).
- Done return: done_out = done of the selected handler. Dones of non-selected handlers are ignored.
- Op data is not modified. Handlers read op directly from the shared op bus.
- REGISTER_OUT=0:
  - Purely combinational.
  - A change of op.cmd while trigger_in is held high moves the trigger to the new handler in the same cycle.
  - clk/reset unused except for lint.
- REGISTER_OUT=1:
  - lin/circ/dummy triggers and done_out are registered on posedge clk.
  - Outputs reflect the inputs of the previous cycle.
  - Same one-hot-or-zero invariant holds.
- Reset (REGISTER_OUT=1): reset high asynchronously clears all triggers and done_out to 0. They stay 0 while reset is asserted. Normal routing resumes at the first clk edge after release.
- Reset mid-operation: outstanding trigger is dropped. The upstream must re-issue it.
- trigger_in = 0: all handler triggers are 0 regardless of op.cmd. done_out still follows the selected handler's done.
- Simultaneous dones from several handlers: only the selected one is visible.
- No internal state beyond the optional output flops. No FSM.

Decomposition:
- Package op_pkg holds:
  - op_cmd_e: OP_CMD_G00, G01, G02, G03, G90, G91, plus spare codes.
  - op_st: packed struct {cmd, arg0..arg4}.
  - handler_sel_e: SEL_LIN, SEL_CIRC, SEL_DUMMY.
- Interface OpHandler_IF: trigger, done; modports master/slave.
- Sub-module op_cmd_to_handler_sel: pure combinational decode op_cmd_e -> handler_sel_e, reused by other routing blocks.
- The top does the demux/mux plus the optional register stage.

Test Plan:
- REGISTER_OUT=0, trigger_in=1, op.cmd=G00, wait 2 clk -> lin=1, circ=0, dummy=0. Repeat with cmd=G01 -> same.
- trigger_in=1, cmd=G02 then G03, 2 clk each -> lin=0, circ=1, dummy=0 both times.
- trigger_in=1, cmd=G90, G91, then an undefined code -> lin=0, circ=0, dummy=1 each time.
- trigger_in=0 for each cmd -> all triggers 0. Drive only circ_done=1 with cmd=G02 -> done_out=1. Same done with cmd=G00 -> done_out=0.
- REGISTER_OUT=1, reset=1 -> all outputs 0. Release reset, trigger_in=1, cmd=G01 -> lin=1 exactly one clk after inputs are applied. Switch to cmd=G02 -> lin falls and circ rises on the next clk.
- Randomized cmd/trigger/done for 1000 cycles -> one-hot-or-zero invariant holds and done_out equals the selected handler's done every cycle.

Source files
------------

// File: rtl/op_pkg.sv
// Shared op-bus types and handler-select encoding for the op-handler routing blocks.
package op_pkg;

    localparam int ARG_W = 16;

    typedef enum logic [3:0] {
        OP_CMD_G00    = 4'd0,
        OP_CMD_G01    = 4'd1,
        OP_CMD_G02    = 4'd2,
        OP_CMD_G03    = 4'd3,
        OP_CMD_G90    = 4'd4,
        OP_CMD_G91    = 4'd5,
        OP_CMD_SPARE6 = 4'd6,
        OP_CMD_SPARE7 = 4'd7
    } op_cmd_e;

    typedef struct packed {
        op_cmd_e          cmd;
        logic [ARG_W-1:0] arg0;
        logic [ARG_W-1:0] arg1;
        logic [ARG_W-1:0] arg2;
        logic [ARG_W-1:0] arg3;
        logic [ARG_W-1:0] arg4;
    } op_st;

    typedef enum logic [1:0] {
        SEL_LIN   = 2'd0,
        SEL_CIRC  = 2'd1,
        SEL_DUMMY = 2'd2
    } handler_sel_e;

endpackage

// File: rtl/op_handler_if.sv
// Trigger/done handshake between an op requester (master) and an op handler (slave).
interface OpHandler_IF;
    logic trigger;
    logic done;

    modport master (output trigger, input done);
    modport slave  (input trigger, output done);
endinterface

// File: rtl/op_cmd_to_handler_sel.sv
// Decodes an op command to the handler that services it; unknown codes go to the dummy handler.
module op_cmd_to_handler_sel
    import op_pkg::*;
(
    input  op_cmd_e      cmd_i,
    output handler_sel_e sel_o
);

    always_comb begin
        sel_o = SEL_DUMMY;
        case (cmd_i)
            OP_CMD_G00, OP_CMD_G01: sel_o = SEL_LIN;
            OP_CMD_G02, OP_CMD_G03: sel_o = SEL_CIRC;
            default:                sel_o = SEL_DUMMY;
        endcase
    end

endmodule

// File: rtl/op_handler_input_chooser.sv
// Routes the upstream trigger to one of three op handlers and returns that handler's done,
// with an optional one-cycle output register stage.
module op_handler_input_chooser
    import op_pkg::*;
#(
    parameter bit REGISTER_OUT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  op_st op,
    input  logic trigger_in,
    output logic done_out,
    output logic lin_trigger,
    input  logic lin_done,
    output logic circ_trigger,
    input  logic circ_done,
    output logic dummy_trigger,
    input  logic dummy_done
);

    handler_sel_e sel;
    logic         lin_trig_d;
    logic         circ_trig_d;
    logic         dummy_trig_d;
    logic         done_d;

    OpHandler_IF lin_if ();
    OpHandler_IF circ_if ();
    OpHandler_IF dummy_if ();

    op_cmd_to_handler_sel u_sel (
        .cmd_i (op.cmd),
        .sel_o (sel)
    );

    assign lin_if.done   = lin_done;
    assign circ_if.done  = circ_done;
    assign dummy_if.done = dummy_done;

    always_comb begin
        lin_trig_d   = trigger_in && (sel == SEL_LIN);
        circ_trig_d  = trigger_in && (sel == SEL_CIRC);
        dummy_trig_d = trigger_in && (sel == SEL_DUMMY);
        done_d       = dummy_if.done;
        case (sel)
            SEL_LIN:  done_d = lin_if.done;
            SEL_CIRC: done_d = circ_if.done;
            default:  done_d = dummy_if.done;
        endcase
    end

    generate
        if (REGISTER_OUT) begin : g_reg
            logic lin_trig_q;
            logic circ_trig_q;
            logic dummy_trig_q;
            logic done_q;

            // A reset drops any outstanding trigger; upstream must re-issue it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lin_trig_q   <= 1'b0;
                    circ_trig_q  <= 1'b0;
                    dummy_trig_q <= 1'b0;
                    done_q       <= 1'b0;
                end else begin
                    lin_trig_q   <= lin_trig_d;
                    circ_trig_q  <= circ_trig_d;
                    dummy_trig_q <= dummy_trig_d;
                    done_q       <= done_d;
                end
            end

            assign lin_if.trigger   = lin_trig_q;
            assign circ_if.trigger  = circ_trig_q;
            assign dummy_if.trigger = dummy_trig_q;
            assign done_out         = done_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;

            assign lin_if.trigger   = lin_trig_d;
            assign circ_if.trigger  = circ_trig_d;
            assign dummy_if.trigger = dummy_trig_d;
            assign done_out         = done_d;
        end
    endgenerate

    assign lin_trigger   = lin_if.trigger;
    assign circ_trigger  = circ_if.trigger;
    assign dummy_trigger = dummy_if.trigger;

    // Handlers read the op arguments straight from the shared bus.
    logic unused_args;
    assign unused_args = ^{op.arg0, op.arg1, op.arg2, op.arg3, op.arg4};

endmodule

// File: tb/tb_op_handler_input_chooser.sv
// Scoreboard bench: combinational and registered instances share stimulus; a negedge
// monitor pops expected {lin,circ,dummy,done} vectors and compares them.
module tb_op_handler_input_chooser;
    import op_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    op_st op = '0;
    logic trigger_in = 1'b0;
    logic lin_done = 1'b0;
    logic circ_done = 1'b0;
    logic dummy_done = 1'b0;

    logic c_done, c_lin, c_circ, c_dummy;
    logic r_done, r_lin, r_circ, r_dummy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] v;
        int         cyc;
        string      name;
    } exp_t;

    exp_t q_c[$];
    exp_t q_r[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    op_handler_input_chooser #(.REGISTER_OUT(1'b0)) dut_c (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .trigger_in    (trigger_in),
        .done_out      (c_done),
        .lin_trigger   (c_lin),
        .lin_done      (lin_done),
        .circ_trigger  (c_circ),
        .circ_done     (circ_done),
        .dummy_trigger (c_dummy),
        .dummy_done    (dummy_done)
    );

    op_handler_input_chooser #(.REGISTER_OUT(1'b1)) dut_r (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .trigger_in    (trigger_in),
        .done_out      (r_done),
        .lin_trigger   (r_lin),
        .lin_done      (lin_done),
        .circ_trigger  (r_circ),
        .circ_done     (circ_done),
        .dummy_trigger (r_dummy),
        .dummy_done    (dummy_done)
    );

    // Expected {lin, circ, dummy, done}: G00/G01 linear, G02/G03 circular, all else dummy.
    function automatic logic [3:0] model(logic [3:0] c, logic t, logic ld, logic cd, logic dd);
        case (c)
            4'd0, 4'd1: return {t, 1'b0, 1'b0, ld};
            4'd2, 4'd3: return {1'b0, t, 1'b0, cd};
            default:    return {1'b0, 1'b0, t, dd};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (lin,circ,dummy,done) at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic t, input logic ld, input logic cd,
                        input logic dd, input logic rst, input string nm);
        exp_t e;
        exp_t prev;
        @(posedge clk);
        #1;
        // Asynchronous reset clears the registered outputs before the next edge.
        if (rst && !reset && q_r.size() > 0) begin
            prev = q_r.pop_back();
            prev.v = 4'b0000;
            q_r.push_back(prev);
        end
        reset      = rst;
        op.cmd     = op_cmd_e'(c);
        op.arg0    = 16'($urandom);
        op.arg4    = 16'($urandom);
        trigger_in = t;
        lin_done   = ld;
        circ_done  = cd;
        dummy_done = dd;
        e.v    = model(c, t, ld, cd, dd);
        e.cyc  = cyc;
        e.name = nm;
        q_c.push_back(e);
        if (rst) e.v = 4'b0000;
        q_r.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_c.size() > 0 && q_c[0].cyc == cyc) begin
            e = q_c.pop_front();
            chk({"comb_", e.name}, {c_lin, c_circ, c_dummy, c_done}, e.v);
        end
        if (q_r.size() > 0 && q_r[0].cyc < cyc - 1) begin
            e = q_r.pop_front();
            checks++;
            errors++;
            $display("FAIL reg_stale_%s: entry of cycle %0d not checked, now cycle %0d", e.name, e.cyc, cyc);
        end
        if (q_r.size() > 0 && q_r[0].cyc == cyc - 1) begin
            e = q_r.pop_front();
            chk({"reg_", e.name}, {r_lin, r_circ, r_dummy, r_done}, e.v);
        end
        checks++;
        if ($countones({c_lin, c_circ, c_dummy}) > 1 || $countones({r_lin, r_circ, r_dummy}) > 1) begin
            errors++;
            $display("FAIL onehot: comb %b reg %b required at most one high",
                     {c_lin, c_circ, c_dummy}, {r_lin, r_circ, r_dummy});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "reset0");
        step(4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset1");
        step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g00_a");
        step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g00_b");
        step(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g01_a");
        step(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g01_b");
        step(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g02_a");
        step(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g02_b");
        step(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g03_a");
        step(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g03_b");
        step(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g90_a");
        step(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g90_b");
        step(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g91");
        step(4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "undef9");
        step(4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "undef15");
        for (int c = 0; c < 16; c++) step(4'(c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "trig_off");
        step(4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "circ_done_sel");
        step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "circ_done_unsel");
        step(4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "all_done_lin");
        step(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "others_done_lin");
        step(4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "dummy_not_done");
        step(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "move_g01");
        step(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "move_g02");
        step(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "pre_reset");
        step(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "mid_reset");
        step(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "hold_reset");
        step(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "reissue");
        for (int i = 0; i < 1000; i++)
            step(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b0, "rand");
        step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle0");
        step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle1");
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q_c.size() != 0 || q_r.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d comb and %0d reg entries left, required 0", q_c.size(), q_r.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
